// File: rtl/hall_call_dispatcher.sv
// Hall-call dispatcher: latches hall buttons, scans one call slot per cycle and assigns it to the cheapest lift.
// All outputs registered (button->lamp 1 cycle, assignment within 2*N_FLOORS cycles); no backpressure, buttons are levels.
module hall_call_dispatcher #(
  parameter int N_FLOORS = 12,
  parameter int N_LIFTS  = 10
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [N_FLOORS-1:0]                up_rqst,
  input  logic [N_FLOORS-1:0]                dn_rqst,
  input  logic [N_LIFTS-1:0][N_FLOORS-1:0]   floor_sense,
  input  logic [N_LIFTS-1:0]                 direction,
  input  logic [N_LIFTS-1:0]                 motion,
  input  logic [N_LIFTS-1:0]                 door_open,
  output logic [N_LIFTS-1:0][N_FLOORS-1:0]   assign_up,
  output logic [N_LIFTS-1:0][N_FLOORS-1:0]   assign_dn,
  output logic [N_FLOORS-1:0]                global_up_rqst_status,
  output logic [N_FLOORS-1:0]                global_dn_rqst_status
);

  localparam int FW = (N_FLOORS > 1) ? $clog2(N_FLOORS) : 1;
  localparam int LW = (N_LIFTS > 1) ? $clog2(N_LIFTS) : 1;
  localparam int PW = $clog2(2 * N_FLOORS);
  localparam int CW = $clog2(2 * N_FLOORS) + 1;
  localparam logic [PW-1:0] LAST_SLOT = PW'(2 * N_FLOORS - 1);
  // No up call from the top floor, no down call from the bottom floor.
  localparam logic [N_FLOORS-1:0] UP_MASK = {1'b0, {(N_FLOORS-1){1'b1}}};
  localparam logic [N_FLOORS-1:0] DN_MASK = {{(N_FLOORS-1){1'b1}}, 1'b0};

  logic [N_FLOORS-1:0]               r_pend_up, r_pend_dn;
  logic [N_LIFTS-1:0][N_FLOORS-1:0]  r_asg_up, r_asg_dn;
  logic [FW-1:0]                     r_last_floor [N_LIFTS];
  logic [PW-1:0]                     r_ptr;

  logic [N_FLOORS-1:0]               w_serve_up, w_serve_dn;
  logic [N_FLOORS-1:0]               w_any_asg_up, w_any_asg_dn;
  logic [FW-1:0]                     w_enc [N_LIFTS];
  logic                              w_slot_is_dn;
  logic [PW-1:0]                     w_slot_idx;
  logic [FW-1:0]                     w_slot_floor;
  logic [N_FLOORS-1:0]               w_floor_oh;
  logic                              w_cand;
  logic [CW-1:0]                     w_lf, w_f;
  logic [CW-1:0]                     w_cost [N_LIFTS];
  logic [CW-1:0]                     w_best_cost;
  logic [LW-1:0]                     w_best;

  always_comb begin
    w_serve_up   = '0;
    w_serve_dn   = '0;
    w_any_asg_up = '0;
    w_any_asg_dn = '0;
    for (int l = 0; l < N_LIFTS; l++) begin
      w_enc[l] = '0;
      for (int f = 0; f < N_FLOORS; f++) begin
        if (floor_sense[l][f]) w_enc[l] = FW'(f);
      end
      if (door_open[l] && direction[l])  w_serve_up = w_serve_up | floor_sense[l];
      if (door_open[l] && !direction[l]) w_serve_dn = w_serve_dn | floor_sense[l];
      w_any_asg_up = w_any_asg_up | r_asg_up[l];
      w_any_asg_dn = w_any_asg_dn | r_asg_dn[l];
    end
  end

  // Slot decode: low half of the pointer range are up calls, high half down calls.
  always_comb begin
    w_slot_is_dn = (r_ptr >= PW'(N_FLOORS));
    w_slot_idx   = w_slot_is_dn ? (r_ptr - PW'(N_FLOORS)) : r_ptr;
    w_slot_floor = FW'(w_slot_idx);
    w_floor_oh   = {{(N_FLOORS-1){1'b0}}, 1'b1} << w_slot_floor;
    if (w_slot_is_dn)
      w_cand = r_pend_dn[w_slot_floor] & ~w_serve_dn[w_slot_floor] & ~w_any_asg_dn[w_slot_floor];
    else
      w_cand = r_pend_up[w_slot_floor] & ~w_serve_up[w_slot_floor] & ~w_any_asg_up[w_slot_floor];
  end

  // Distance plus a full-building penalty for a moving lift heading away from the call.
  always_comb begin
    w_lf = '0;
    w_f  = CW'(w_slot_floor);
    for (int l = 0; l < N_LIFTS; l++) begin
      w_lf = CW'(r_last_floor[l]);
      w_cost[l] = (w_lf > w_f) ? (w_lf - w_f) : (w_f - w_lf);
      if (motion[l] && ((direction[l] && (w_lf > w_f)) || (!direction[l] && (w_lf < w_f))))
        w_cost[l] = w_cost[l] + CW'(N_FLOORS);
    end
  end

  // Strict less-than keeps the lowest lift index on ties.
  always_comb begin
    w_best      = '0;
    w_best_cost = w_cost[0];
    for (int l = 1; l < N_LIFTS; l++) begin
      if (w_cost[l] < w_best_cost) begin
        w_best      = LW'(l);
        w_best_cost = w_cost[l];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_up <= '0;
      r_pend_dn <= '0;
      r_asg_up  <= '0;
      r_asg_dn  <= '0;
      r_ptr     <= '0;
      for (int l = 0; l < N_LIFTS; l++) r_last_floor[l] <= '0;
    end else begin
      r_pend_up <= (r_pend_up | (up_rqst & UP_MASK)) & ~w_serve_up;
      r_pend_dn <= (r_pend_dn | (dn_rqst & DN_MASK)) & ~w_serve_dn;
      r_ptr     <= (r_ptr == LAST_SLOT) ? '0 : r_ptr + PW'(1);
      for (int l = 0; l < N_LIFTS; l++) begin
        if (w_cand && !w_slot_is_dn && (w_best == LW'(l)))
          r_asg_up[l] <= (r_asg_up[l] | w_floor_oh) & ~w_serve_up;
        else
          r_asg_up[l] <= r_asg_up[l] & ~w_serve_up;
        if (w_cand && w_slot_is_dn && (w_best == LW'(l)))
          r_asg_dn[l] <= (r_asg_dn[l] | w_floor_oh) & ~w_serve_dn;
        else
          r_asg_dn[l] <= r_asg_dn[l] & ~w_serve_dn;
        if (|floor_sense[l]) r_last_floor[l] <= w_enc[l];
      end
    end
  end

  assign assign_up             = r_asg_up;
  assign assign_dn             = r_asg_dn;
  assign global_up_rqst_status = r_pend_up;
  assign global_dn_rqst_status = r_pend_dn;

endmodule
